// File: rtl/blender_issue_arbiter_if.sv
// Request, core and response bundle for blender_issue_arbiter.
// master = requesters/core/response sink side, slave = the arbiter.
interface blender_issue_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned LATENCY = 6,
    parameter int unsigned DATA_W  = 32
);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [4*NUM_REQ-1:0]      req_op;
    logic [DATA_W*NUM_REQ-1:0] req_op1;
    logic [DATA_W*NUM_REQ-1:0] req_op2;

    logic [3:0]                core_operation;
    logic [DATA_W-1:0]         core_op1;
    logic [DATA_W-1:0]         core_op2;
    logic                      core_clk_enable;
    logic [DATA_W-1:0]         core_result;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;

    logic [CNT_W-1:0]          inflight_cnt;
    logic                      busy;

    modport master (
        output req_valid, req_op, req_op1, req_op2, core_result, rsp_ready,
        input  req_ready, core_operation, core_op1, core_op2, core_clk_enable,
        input  rsp_valid, rsp_id, rsp_data, inflight_cnt, busy
    );

    modport slave (
        input  req_valid, req_op, req_op1, req_op2, core_result, rsp_ready,
        output req_ready, core_operation, core_op1, core_op2, core_clk_enable,
        output rsp_valid, rsp_id, rsp_data, inflight_cnt, busy
    );
endinterface

// File: rtl/blender_issue_arbiter.sv
// Round-robin issue of NUM_REQ requesters onto one shared blender core, with a latency-matched
// tag pipeline returning results to their owners. BLENDER_ARB_PRIO_EN gives requester 0 strict priority.
module blender_issue_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned LATENCY = 6,
    parameter int unsigned DATA_W  = 32
) (
    input logic                   clk,
    input logic                   reset,
    blender_issue_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    logic [LATENCY-1:0]           tag_valid;
    logic [LATENCY-1:0][ID_W-1:0] tag_id;
    logic [ID_W-1:0]              rr_ptr;
    logic [CNT_W-1:0]             cnt_q;

    logic                         grant_any;
    logic [ID_W-1:0]              grant_id;
    logic                         head_stall;
    logic                         can_issue;
    logic                         issue;
    logic                         shift_en;
    logic                         retire;
    logic                         rr_update;
    logic [NUM_REQ-1:0]           ready_c;
    logic [3:0]                   op_c;
    logic [DATA_W-1:0]            op1_c;
    logic [DATA_W-1:0]            op2_c;

    // First valid requester at or after rr_ptr, wrapping to the lowest valid one.
    always_comb begin : grant_sel
        logic            hi_any;
        logic [ID_W-1:0] hi_id;
        logic            lo_any;
        logic [ID_W-1:0] lo_id;
        hi_any = 1'b0;
        hi_id  = '0;
        lo_any = 1'b0;
        lo_id  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!hi_any && bus.req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
                hi_any = 1'b1;
                hi_id  = ID_W'(i);
            end
            if (!lo_any && bus.req_valid[i]) begin
                lo_any = 1'b1;
                lo_id  = ID_W'(i);
            end
        end
        grant_any = hi_any | lo_any;
        grant_id  = hi_any ? hi_id : lo_id;
`ifdef BLENDER_ARB_PRIO_EN
        if (bus.req_valid[0]) begin
            grant_any = 1'b1;
            grant_id  = '0;
        end
`endif
    end

`ifdef BLENDER_ARB_PRIO_EN
    assign rr_update = issue & ~bus.req_valid[0];
`else
    assign rr_update = issue;
`endif

    assign head_stall = tag_valid[LATENCY-1] & ~bus.rsp_ready;
    assign can_issue  = ~head_stall & ~reset;
    assign issue      = grant_any & can_issue;
    assign shift_en   = ~head_stall & ~reset & (issue | (cnt_q != '0));
    assign retire     = tag_valid[LATENCY-1] & bus.rsp_ready;

    // Route the granted requester's operation onto the core; zeros when nothing issues.
    always_comb begin : issue_mux
        ready_c = '0;
        op_c    = '0;
        op1_c   = '0;
        op2_c   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (issue && (grant_id == ID_W'(i))) begin
                ready_c[i] = 1'b1;
                op_c       = bus.req_op[4*i +: 4];
                op1_c      = bus.req_op1[DATA_W*i +: DATA_W];
                op2_c      = bus.req_op2[DATA_W*i +: DATA_W];
            end
        end
    end

    // Tag pipeline advances only with the core clock so tags stay aligned with core data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_valid <= '0;
            tag_id    <= '0;
            rr_ptr    <= '0;
            cnt_q     <= '0;
        end else begin
            if (shift_en) begin
                tag_valid <= {tag_valid[LATENCY-2:0], issue};
                tag_id    <= {tag_id[LATENCY-2:0], grant_id};
            end
            if (rr_update) begin
                rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end
            case ({issue, retire})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign bus.req_ready       = ready_c;
    assign bus.core_operation  = op_c;
    assign bus.core_op1        = op1_c;
    assign bus.core_op2        = op2_c;
    assign bus.core_clk_enable = shift_en;
    assign bus.rsp_valid       = tag_valid[LATENCY-1];
    assign bus.rsp_id          = tag_id[LATENCY-1];
    assign bus.rsp_data        = bus.core_result;
    assign bus.inflight_cnt    = cnt_q;
    assign bus.busy            = (cnt_q != '0);

endmodule

// File: tb/tb_blender_issue_arbiter.sv
// Bench for blender_issue_arbiter: stand-in blender core plus a queue-based reference of
// issued operations aged by enabled core edges.
module tb_blender_issue_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned IDW = 2;
    localparam int unsigned LAT = 6;
    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = $clog2(LAT + 1);

    logic clk;
    logic reset;

    blender_issue_arbiter_if #(.NUM_REQ(N), .ID_W(IDW), .LATENCY(LAT), .DATA_W(DW)) bus ();

    blender_issue_arbiter #(.NUM_REQ(N), .ID_W(IDW), .LATENCY(LAT), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stand-in core behaviour; op 0 is the passthrough that adds 123522.
    function automatic logic [DW-1:0] core_fn(input logic [3:0] op, input logic [DW-1:0] x,
                                              input logic [DW-1:0] y);
        case (op)
            4'd0:    return x + y + 32'd123522;
            4'd1:    return x - y;
            4'd2:    return x ^ y;
            4'd3:    return x & y;
            default: return (x | y) + DW'(op);
        endcase
    endfunction

    logic [DW-1:0] core_pipe [LAT];
    always @(posedge clk) begin
        if (bus.core_clk_enable) begin
            core_pipe[0] <= core_fn(bus.core_operation, bus.core_op1, bus.core_op2);
            for (int k = 1; k < LAT; k++) core_pipe[k] <= core_pipe[k-1];
        end
    end
    assign bus.core_result = core_pipe[LAT-1];

    // Stimulus state
    logic [N-1:0]  rv;
    logic          rsp_rdy;
    logic [3:0]    op_a [N];
    logic [DW-1:0] a1 [N];
    logic [DW-1:0] a2 [N];

    // Reference: in-flight operations in issue order, age = enabled core edges since issue
    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            age;
    } op_t;
    op_t q[$];
    int  m_ptr;

    int n_cmp;
    int n_bad;

    logic [N+CW+1:0]     exp_ctl, obs_ctl;
    logic [4+2*DW-1:0]   exp_core, obs_core;
    logic [IDW+DW:0]     exp_rsp, obs_rsp;
    int                  exp_grant, obs_grant;
    logic                obs_en, obs_busy;
    logic [CW-1:0]       obs_cnt;

    function automatic int pick(input logic [N-1:0] v, input int ptr);
`ifdef BLENDER_ARB_PRIO_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < int'(N); k++) begin
            int i;
            i = (ptr + k) % int'(N);
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic new_req(input int i);
        op_a[i] = 4'($urandom_range(0, 15));
        a1[i]   = $urandom;
        a2[i]   = $urandom;
    endtask

    // One clock cycle: drive at negedge, predict and sample, then advance the reference.
    task automatic step();
        op_t          e;
        bit           head, stall, iss, en;
        int           g;
        logic [N-1:0] er;
        bus.req_valid = rv;
        bus.rsp_ready = rsp_rdy;
        for (int i = 0; i < int'(N); i++) begin
            bus.req_op[4*i +: 4]    = op_a[i];
            bus.req_op1[DW*i +: DW] = a1[i];
            bus.req_op2[DW*i +: DW] = a2[i];
        end
        #1;
        head  = (q.size() > 0) && (q[0].age == int'(LAT));
        stall = head && !rsp_rdy;
        g     = pick(rv, m_ptr);
        iss   = (g >= 0) && !stall;
        er    = '0;
        if (iss) er[g] = 1'b1;
        en        = !stall && (iss || q.size() > 0);
        exp_ctl   = {er, en, CW'(q.size()), q.size() != 0};
        exp_core  = iss ? {op_a[g], a1[g], a2[g]} : '0;
        exp_rsp   = head ? {1'b1, IDW'(q[0].id), q[0].data} : '0;
        exp_grant = iss ? g : -1;
        obs_ctl   = {bus.req_ready, bus.core_clk_enable, bus.inflight_cnt, bus.busy};
        obs_core  = {bus.core_operation, bus.core_op1, bus.core_op2};
        obs_rsp   = bus.rsp_valid ? {1'b1, bus.rsp_id, bus.rsp_data} : '0;
        obs_en    = bus.core_clk_enable;
        obs_busy  = bus.busy;
        obs_cnt   = bus.inflight_cnt;
        obs_grant = -1;
        for (int i = 0; i < int'(N); i++) if (bus.req_ready[i]) obs_grant = i;
        @(posedge clk);
        if (en) begin
            if (head && rsp_rdy) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (iss) begin
                e.id   = g;
                e.data = core_fn(op_a[g], a1[g], a2[g]);
                e.age  = 1;
                q.push_back(e);
            end
        end
`ifdef BLENDER_ARB_PRIO_EN
        if (iss && g != 0) m_ptr = (g + 1) % int'(N);
`else
        if (iss) m_ptr = (g + 1) % int'(N);
`endif
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rv    = '0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        q.delete();
        m_ptr = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [N+CW+2:0] v;
        rv = '1;
        bus.req_valid = rv;
        bus.rsp_ready = 1'b1;
        #1;
        v = {bus.req_ready, bus.core_clk_enable, bus.inflight_cnt, bus.busy, bus.rsp_valid};
        n_cmp++;
        if (v !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h want=0", v);
        end
        @(negedge clk);
        reset = 1'b0;
        rv    = '0;
        q.delete();
        m_ptr = 0;
        step();
        n_cmp++;
        if (obs_ctl !== exp_ctl) begin
            n_bad++;
            $display("FAIL reset_idle_ctl got=%h want=%h", obs_ctl, exp_ctl);
        end
    endtask

    task automatic test_single_issue();
        int            hit;
        logic [IDW:0]  got_id;
        logic [DW-1:0] got_data;
        hit = -1; got_id = '1; got_data = '0;
        rsp_rdy = 1'b1;
        op_a[0] = 4'b0000; a1[0] = 32'd1; a2[0] = 32'd2;
        rv = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            step();
            rv = '0;
            n_cmp++;
            if (obs_ctl !== exp_ctl) begin
                n_bad++;
                $display("FAIL single_ctl[%0d] got=%h want=%h", i, obs_ctl, exp_ctl);
            end
            if (obs_rsp[IDW+DW] && hit < 0) begin
                hit = i; got_id = {1'b0, obs_rsp[DW +: IDW]}; got_data = obs_rsp[DW-1:0];
            end
        end
        n_cmp++;
        if (hit !== 6) begin n_bad++; $display("FAIL single_latency got=%0d want=6", hit); end
        n_cmp++;
        if (got_data !== 32'd123525 || got_id !== '0) begin
            n_bad++;
            $display("FAIL single_rsp got id=%0d data=%0d want id=0 data=123525", got_id, got_data);
        end
    endtask

    task automatic test_round_robin();
        int ids[$];
        int first, last;
        first = -1; last = -1;
        apply_reset();
        rsp_rdy = 1'b1;
        for (int i = 0; i < int'(N); i++) new_req(i);
        rv = '1;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) rv = '0;
            step();
            if (i < 8) begin
                n_cmp++;
                if (obs_grant !== i % 4) begin
                    n_bad++; $display("FAIL rr_grant[%0d] got=%0d want=%0d", i, obs_grant, i % 4);
                end
                n_cmp++;
                if (obs_core !== exp_core) begin
                    n_bad++; $display("FAIL rr_core[%0d] got=%h want=%h", i, obs_core, exp_core);
                end
                if (exp_grant >= 0) new_req(exp_grant);
            end
            n_cmp++;
            if (obs_rsp !== exp_rsp) begin
                n_bad++; $display("FAIL rr_rsp[%0d] got=%h want=%h", i, obs_rsp, exp_rsp);
            end
            if (obs_rsp[IDW+DW]) begin
                ids.push_back(int'(obs_rsp[DW +: IDW]));
                if (first < 0) first = i;
                last = i;
            end
        end
        n_cmp++;
        if (ids.size() != 8 || last - first != 7) begin
            n_bad++; $display("FAIL rr_rsp_count got=%0d span=%0d want=8 span=7", ids.size(), last - first);
        end
        foreach (ids[i]) begin
            n_cmp++;
            if (ids[i] != i % 4) begin n_bad++; $display("FAIL rr_rsp_id[%0d] got=%0d want=%0d", i, ids[i], i % 4); end
        end
    endtask

    task automatic test_backpressure();
        logic [IDW+DW:0] held;
        int nrsp;
        held = '0; nrsp = 0;
        rsp_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rv = '0;
            rv[$urandom_range(0, N-1)] = 1'b1;
            new_req(int'($urandom_range(0, N-1)));
            for (int j = 0; j < int'(N); j++) if (rv[j]) new_req(j);
            step();
            n_cmp++;
            if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL bp_fill_ctl[%0d] got=%h want=%h", i, obs_ctl, exp_ctl); end
        end
        rsp_rdy = 1'b0;
        rv = '1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (obs_en !== 1'b0 || obs_grant != -1 || obs_cnt !== CW'(6)) begin
                n_bad++;
                $display("FAIL bp_stall[%0d] got en=%0b grant=%0d cnt=%0d want en=0 grant=-1 cnt=6", i, obs_en, obs_grant, obs_cnt);
            end
            if (i == 0) held = obs_rsp;
            n_cmp++;
            if (obs_rsp !== held || obs_rsp !== exp_rsp) begin
                n_bad++; $display("FAIL bp_hold[%0d] got=%h want=%h", i, obs_rsp, exp_rsp);
            end
        end
        rsp_rdy = 1'b1;
        rv = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (obs_rsp !== exp_rsp) begin n_bad++; $display("FAIL bp_drain[%0d] got=%h want=%h", i, obs_rsp, exp_rsp); end
            if (i < 6 && obs_rsp[IDW+DW]) nrsp++;
        end
        n_cmp++;
        if (nrsp != 6) begin n_bad++; $display("FAIL bp_count got=%0d want=6", nrsp); end
    endtask

    task automatic test_idle();
        rv = '0;
        rsp_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (obs_en !== 1'b0 || obs_busy !== 1'b0 || obs_ctl !== exp_ctl) begin
                n_bad++; $display("FAIL idle[%0d] got en=%0b busy=%0b ctl=%h want en=0 busy=0 ctl=%h", i, obs_en, obs_busy, obs_ctl, exp_ctl);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [N+CW+2:0] v;
        int nrsp;
        nrsp = 0;
        rsp_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rv = '0;
            rv[$urandom_range(0, N-1)] = 1'b1;
            step();
        end
        n_cmp++;
        if (obs_cnt !== CW'(2)) begin n_bad++; $display("FAIL midrst_pre_cnt got=%0d want=2", obs_cnt); end
        rv = '1;
        bus.req_valid = rv;
        #2;
        reset = 1'b1;
        #1;
        v = {bus.req_ready, bus.core_clk_enable, bus.inflight_cnt, bus.busy, bus.rsp_valid};
        n_cmp++;
        if (v !== '0) begin n_bad++; $display("FAIL midrst_outputs got=%h want=0", v); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        m_ptr = 0;
        for (int i = 0; i < int'(N); i++) new_req(i);
        rv = '1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 0) begin
                n_cmp++;
                if (obs_grant !== 0) begin n_bad++; $display("FAIL midrst_first_grant got=%0d want=0", obs_grant); end
                rv = '0;
            end
            n_cmp++;
            if (obs_rsp !== exp_rsp) begin n_bad++; $display("FAIL midrst_rsp[%0d] got=%h want=%h", i, obs_rsp, exp_rsp); end
            if (obs_rsp[IDW+DW]) nrsp++;
        end
        n_cmp++;
        if (nrsp != 1) begin n_bad++; $display("FAIL midrst_rsp_count got=%0d want=1", nrsp); end
    endtask

`ifdef BLENDER_ARB_PRIO_EN
    task automatic test_priority();
        apply_reset();
        rsp_rdy = 1'b1;
        new_req(0); new_req(2);
        rv = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (obs_grant !== 0) begin n_bad++; $display("FAIL prio_grant[%0d] got=%0d want=0", i, obs_grant); end
        end
        rv = 4'b0100;
        step();
        n_cmp++;
        if (obs_grant !== 2) begin n_bad++; $display("FAIL prio_release got=%0d want=2", obs_grant); end
        rv = '0;
        repeat (8) step();
    endtask
`endif

    task automatic test_random();
        bit pend [N];
        apply_reset();
        for (int i = 0; i < int'(N); i++) pend[i] = 1'b0;
        for (int c = 0; c < 320; c++) begin
            if (c < 300) begin
                for (int i = 0; i < int'(N); i++) begin
                    if (!pend[i] && $urandom_range(0, 2) == 0) begin
                        pend[i] = 1'b1;
                        new_req(i);
                    end
                end
                rsp_rdy = ($urandom_range(0, 3) != 0);
            end else begin
                for (int i = 0; i < int'(N); i++) pend[i] = 1'b0;
                rsp_rdy = 1'b1;
            end
            for (int i = 0; i < int'(N); i++) rv[i] = pend[i];
            step();
            if (exp_grant >= 0) pend[exp_grant] = 1'b0;
            n_cmp++;
            if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL rnd_ctl[%0d] got=%h want=%h", c, obs_ctl, exp_ctl); end
            n_cmp++;
            if (obs_core !== exp_core) begin n_bad++; $display("FAIL rnd_core[%0d] got=%h want=%h", c, obs_core, exp_core); end
            n_cmp++;
            if (obs_rsp !== exp_rsp) begin n_bad++; $display("FAIL rnd_rsp[%0d] got=%h want=%h", c, obs_rsp, exp_rsp); end
        end
        n_cmp++;
        if (obs_cnt !== '0 || q.size() != 0) begin
            n_bad++; $display("FAIL rnd_drained got cnt=%0d model=%0d want 0", obs_cnt, q.size());
        end
    endtask

    initial begin
        clk     = 1'b0;
        reset   = 1'b1;
        rv      = '0;
        rsp_rdy = 1'b1;
        n_cmp   = 0;
        n_bad   = 0;
        m_ptr   = 0;
        for (int i = 0; i < int'(N); i++) begin
            op_a[i] = '0; a1[i] = '0; a2[i] = '0;
        end
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_op1   = '0;
        bus.req_op2   = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_single_issue();
        test_round_robin();
        test_backpressure();
        test_idle();
        test_reset_midflight();
`ifdef BLENDER_ARB_PRIO_EN
        test_priority();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
